// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and enums for the memory arbiter slice
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-requester memory access bundle
interface mem_arbiter_if #(
  parameter int DW = cpu_pkg::DATA_W,
  parameter int AW = cpu_pkg::ADDR_W
);
  import cpu_pkg::*;

  logic          req_a;
  logic          we_a;
  logic          lock_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;

  logic          req_b;
  logic          we_b;
  logic          lock_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;

  logic          lock_timeout;

  modport master (
    output req_a, we_a, lock_a, addr_a, wdata_a,
    output req_b, we_b, lock_b, addr_b, wdata_b,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  lock_timeout
  );

  modport slave (
    input  req_a, we_a, lock_a, addr_a, wdata_a,
    input  req_b, we_b, lock_b, addr_b, wdata_b,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output lock_timeout
  );

endinterface

// File: rtl/mem_arbiter_mem_array.sv
// rtl/mem_arbiter_mem_array.sv - single-port synchronous RAM with registered read data
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage write; contents survive reset and are loaded by the loader port
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register, only refreshed by a read access
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter with bounded lock over a shared 16x8 memory
module mem_arbiter #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int LOCK_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);
  import cpu_pkg::*;

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  owner_t            owner;
  owner_t            eff_owner;
  port_t             last;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  base_cnt;
  logic              gnt_a_c;
  logic              gnt_b_c;
  logic              rvalid_a_q;
  logic              rvalid_b_q;
  logic              timeout_q;
  logic [DATA_W-1:0] held_a;
  logic [DATA_W-1:0] held_b;
  logic [DATA_W-1:0] ram_rdata;

  logic              acc_en;
  logic              acc_we;
  logic              acc_lock;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // Grant decision: an owner that stopped requesting loses ownership this same cycle
  always_comb begin
    eff_owner = owner;
    if (owner == OWN_A && !bus.req_a) eff_owner = OWN_NONE;
    if (owner == OWN_B && !bus.req_b) eff_owner = OWN_NONE;
    base_cnt = (eff_owner == OWN_NONE) ? '0 : lock_cnt;
    gnt_a_c  = 1'b0;
    gnt_b_c  = 1'b0;
    if (!reset) begin
      case (eff_owner)
        OWN_A:   gnt_a_c = 1'b1;
        OWN_B:   gnt_b_c = 1'b1;
        default: begin
          if (bus.req_a && bus.req_b) begin
            if (last == PORT_B) gnt_a_c = 1'b1;
            else                gnt_b_c = 1'b1;
          end else begin
            gnt_a_c = bus.req_a;
            gnt_b_c = bus.req_b;
          end
        end
      endcase
    end
  end

  // Steer the granted port onto the single RAM port
  always_comb begin
    acc_en    = gnt_a_c | gnt_b_c;
    acc_we    = gnt_b_c ? bus.we_b    : bus.we_a;
    acc_lock  = gnt_b_c ? bus.lock_b  : bus.lock_a;
    acc_addr  = gnt_b_c ? bus.addr_b  : bus.addr_a;
    acc_wdata = gnt_b_c ? bus.wdata_b : bus.wdata_a;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .en    (acc_en),
    .we    (acc_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // Lock FSM, round-robin pointer, read-valid and timeout pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_NONE;
      lock_cnt   <= '0;
      last       <= PORT_B;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      rvalid_a_q <= gnt_a_c && !bus.we_a;
      rvalid_b_q <= gnt_b_c && !bus.we_b;
      timeout_q  <= 1'b0;
      owner      <= eff_owner;
      lock_cnt   <= base_cnt;
      if (acc_en) begin
        last <= gnt_b_c ? PORT_B : PORT_A;
        if (!acc_lock) begin
          owner    <= OWN_NONE;
          lock_cnt <= '0;
        end else if (base_cnt == CNT_LAST) begin
          owner     <= OWN_NONE;
          lock_cnt  <= '0;
          timeout_q <= 1'b1;
        end else begin
          owner    <= gnt_b_c ? OWN_B : OWN_A;
          lock_cnt <= base_cnt + 1'b1;
        end
      end
    end
  end

  // Per-port copy of the last read so a port's data survives the other port's reads
  always_ff @(posedge clk) begin
    if (reset) begin
      held_a <= '0;
      held_b <= '0;
    end else begin
      if (rvalid_a_q) held_a <= ram_rdata;
      if (rvalid_b_q) held_b <= ram_rdata;
    end
  end

  assign bus.gnt_a        = gnt_a_c;
  assign bus.gnt_b        = gnt_b_c;
  assign bus.rvalid_a     = rvalid_a_q & ~reset;
  assign bus.rvalid_b     = rvalid_b_q & ~reset;
  assign bus.rdata_a      = bus.rvalid_a ? ram_rdata : held_a;
  assign bus.rdata_b      = bus.rvalid_b ? ram_rdata : held_b;
  assign bus.lock_timeout = timeout_q & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;

  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  int         m_owner = 0;   // 0 none, 1 A, 2 B
  int         m_eff   = 0;
  int         m_cnt   = 0;
  int         m_last  = 1;   // 0 A, 1 B
  logic [7:0] m_mem [16];
  bit         m_known [16];
  bit         mga, mgb;
  bit         e_rva = 0, e_rvb = 0, e_to = 0;
  logic [7:0] e_rda = 0, e_rdb = 0;
  bit         e_rda_k = 0, e_rdb_k = 0;
  logic       obs_ga, obs_gb, obs_rva, obs_rvb, obs_to;
  logic [7:0] obs_rda, obs_rdb;
  logic [7:0] ld [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic drive_a(input bit r, input bit w, input bit l, input logic [3:0] ad, input logic [7:0] d);
    bus.req_a = r; bus.we_a = w; bus.lock_a = l; bus.addr_a = ad; bus.wdata_a = d;
  endtask

  task automatic drive_b(input bit r, input bit w, input bit l, input logic [3:0] ad, input logic [7:0] d);
    bus.req_b = r; bus.we_b = w; bus.lock_b = l; bus.addr_b = ad; bus.wdata_b = d;
  endtask

  // Who should be granted now, from ownership, requests and the last winner
  task automatic model_gnt();
    mga = 0; mgb = 0;
    m_eff = m_owner;
    if (m_owner == 1 && !bus.req_a) m_eff = 0;
    if (m_owner == 2 && !bus.req_b) m_eff = 0;
    if (!reset) begin
      if (m_eff == 1) mga = 1;
      else if (m_eff == 2) mgb = 1;
      else if (bus.req_a && bus.req_b) begin
        if (m_last == 1) mga = 1; else mgb = 1;
      end else begin
        mga = bus.req_a; mgb = bus.req_b;
      end
    end
  endtask

  task automatic model_update();
    bit b, w, lk;
    logic [3:0] ad;
    logic [7:0] d;
    int n;
    if (reset) begin
      m_owner = 0; m_cnt = 0; m_last = 1;
      e_rva = 0; e_rvb = 0; e_to = 0;
      e_rda = 0; e_rdb = 0; e_rda_k = 1; e_rdb_k = 1;
    end else begin
      e_rva = 0; e_rvb = 0; e_to = 0;
      if (mga || mgb) begin
        b  = mgb;
        w  = b ? bus.we_b : bus.we_a;
        lk = b ? bus.lock_b : bus.lock_a;
        ad = b ? bus.addr_b : bus.addr_a;
        d  = b ? bus.wdata_b : bus.wdata_a;
        if (w) begin
          m_mem[ad] = d; m_known[ad] = 1;
        end else if (b) begin
          e_rvb = 1; e_rdb = m_mem[ad]; e_rdb_k = m_known[ad];
        end else begin
          e_rva = 1; e_rda = m_mem[ad]; e_rda_k = m_known[ad];
        end
        m_last = b ? 1 : 0;
        if (!lk) begin
          m_owner = 0; m_cnt = 0;
        end else begin
          n = ((m_eff == 0) ? 0 : m_cnt) + 1;
          if (n >= LOCK_MAX) begin
            m_owner = 0; m_cnt = 0; e_to = 1;
          end else begin
            m_owner = b ? 2 : 1; m_cnt = n;
          end
        end
      end else begin
        m_owner = m_eff;
        if (m_eff == 0) m_cnt = 0;
      end
    end
  endtask

  // One clock: predict, sample on the falling edge, then advance the model at the rising edge
  task automatic step();
    model_gnt();
    @(negedge clk);
    obs_ga = bus.gnt_a; obs_gb = bus.gnt_b;
    obs_rva = bus.rvalid_a; obs_rvb = bus.rvalid_b;
    obs_rda = bus.rdata_a; obs_rdb = bus.rdata_b;
    obs_to = bus.lock_timeout;
    check("gnt_a", obs_ga, mga);
    check("gnt_b", obs_gb, mgb);
    check("rvalid_a", obs_rva, reset ? 1'b0 : e_rva);
    check("rvalid_b", obs_rvb, reset ? 1'b0 : e_rvb);
    check("lock_timeout", obs_to, reset ? 1'b0 : e_to);
    if (!reset && e_rda_k) check("rdata_a", obs_rda, e_rda);
    if (!reset && e_rdb_k) check("rdata_b", obs_rdb, e_rdb);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit pa, pb;
    bit [6:0] ra, rb;
    logic [3:0] aa, ab;
    logic [7:0] da, db;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 0; m_known[i] = 0;
    end
    drive_a(1, 0, 0, 4'd0, 8'h00);
    drive_b(1, 0, 0, 4'd1, 8'h00);
    reset = 1;
    @(posedge clk); #1;

    // reset with both requesting, then A wins the first tie
    step();
    step();
    check("rst_gnt_a", obs_ga, 1'b0);
    check("rst_gnt_b", obs_gb, 1'b0);
    reset = 0;
    step();
    check("first_gnt_a", obs_ga, 1'b1);

    // load every word through port B
    drive_a(0, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      ld[i] = 8'($urandom_range(0, 255));
      if (i == 0) ld[i] = 8'h08;
      if (i == 3) ld[i] = 8'h5A;
      if (i == 5) ld[i] = 8'h03;
      if (i == 7) ld[i] = 8'h89;
      drive_b(1, 1, 0, 4'(i), ld[i]);
      step();
      check("load_gnt_b", obs_gb, 1'b1);
    end

    // fetch addr 7 on port A
    drive_b(0, 0, 0, 4'd0, 8'h00);
    drive_a(1, 0, 0, 4'd7, 8'h00);
    step();
    check("fetch_gnt_a", obs_ga, 1'b1);
    drive_a(0, 0, 0, 4'd0, 8'h00);
    step();
    check("fetch_rvalid_a", obs_rva, 1'b1);
    check("fetch_rdata_a", obs_rda, 8'h89);
    check("fetch_rvalid_b", obs_rvb, 1'b0);

    // contention right after reset alternates A,B,A,B,A,B
    reset = 1;
    step();
    reset = 0;
    drive_a(1, 0, 0, 4'd2, 8'h00);
    drive_b(1, 0, 0, 4'd4, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_gnt_a", obs_ga, (i % 2) == 0);
      check("rr_gnt_b", obs_gb, (i % 2) == 1);
    end

    // locked read-modify-write on addr 5 with B waiting
    drive_a(1, 0, 1, 4'd5, 8'h00);
    drive_b(1, 0, 0, 4'd5, 8'h00);
    step();
    check("rmw_rd_gnt_a", obs_ga, 1'b1);
    drive_a(1, 1, 0, 4'd5, 8'h06);
    step();
    check("rmw_rd_data", obs_rda, 8'h03);
    check("rmw_wr_gnt_a", obs_ga, 1'b1);
    check("rmw_wr_gnt_b", obs_gb, 1'b0);
    drive_a(0, 0, 0, 4'd0, 8'h00);
    step();
    check("rmw_b_gnt", obs_gb, 1'b1);
    drive_b(0, 0, 0, 4'd0, 8'h00);
    step();
    check("rmw_b_rvalid", obs_rvb, 1'b1);
    check("rmw_b_rdata", obs_rdb, 8'h06);

    // lock held past LOCK_MAX is forcibly released
    drive_a(1, 0, 1, 4'd1, 8'h00);
    drive_b(1, 0, 0, 4'd2, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      check("to_gnt_a", obs_ga, i != 4);
      check("to_gnt_b", obs_gb, i == 4);
      check("to_pulse", obs_to, i == 4);
    end
    drive_a(0, 0, 0, 4'd0, 8'h00);
    drive_b(0, 0, 0, 4'd0, 8'h00);
    step();

    // reset suppresses a pending rvalid and a write in the reset cycle
    drive_a(1, 0, 0, 4'd0, 8'h00);
    step();
    drive_a(0, 0, 0, 4'd0, 8'h00);
    drive_b(1, 1, 0, 4'd3, 8'hFF);
    reset = 1;
    step();
    check("rst_rvalid_a", obs_rva, 1'b0);
    check("rst_wr_gnt_b", obs_gb, 1'b0);
    reset = 0;
    drive_b(0, 0, 0, 4'd0, 8'h00);
    step();
    drive_a(1, 0, 0, 4'd3, 8'h00);
    step();
    drive_a(0, 0, 0, 4'd0, 8'h00);
    step();
    check("rst_wr_dropped", obs_rda, 8'h5A);

    // randomized traffic
    pa = 0; pb = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1; ra = 7'($urandom); aa = 4'($urandom); da = 8'($urandom);
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1; rb = 7'($urandom); ab = 4'($urandom); db = 8'($urandom);
      end
      drive_a(pa, ra[0], ra[2:1] == 2'b00, aa, da);
      drive_b(pb, rb[0], rb[2:1] == 2'b00, ab, db);
      reset = ($urandom_range(0, 99) == 0);
      step();
      if (mga) pa = 0;
      if (mgb) pb = 0;
    end
    reset = 0;
    drive_a(0, 0, 0, 4'd0, 8'h00);
    drive_b(0, 0, 0, 4'd0, 8'h00);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
